// File: rtl/lms_weight_update_ctrl.sv
// lms_weight_update_ctrl: sequences the shared 10-bit modified adder unit over
// all filter taps. Each tap fetches two correction terms through a req/valid
// handshake, presents them to the adder with weight[tap_idx], and writes the
// adder result back into the internal weight register file.
// Optional build macro MAU_SAT_EN: clamp write-back to the signed WW-bit range
// and expose a sticky sat_flag output.
module lms_weight_update_ctrl #(
   parameter int NTAPS = 8,
   parameter int IDXW  = 3,
   parameter int WW    = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            clear,
   output logic            busy,
   output logic            done,
   output logic [IDXW-1:0] tap_idx,
   output logic            term_req,
   input  logic            term_valid,
   input  logic [WW-1:0]   term_x,
   input  logic            term_x_neg,
   input  logic [WW-1:0]   term_a,
   input  logic            term_a_neg,
   output logic [WW-1:0]   mau_w,
   output logic [WW-1:0]   mau_x,
   output logic [WW-1:0]   mau_A,
   output logic            mau_y,
   output logic            mau_z,
   output logic            mau_a,
   output logic            mau_b,
   input  logic [WW-1:0]   mau_W,
   input  logic [IDXW-1:0] rd_addr,
`ifdef MAU_SAT_EN
   output logic            sat_flag,
`endif
   output logic [WW-1:0]   rd_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;
   logic [WW-1:0]   weights [NTAPS];
   logic [WW-1:0]   wr_data;
   logic            wr_en;
   logic            clr_en;
   logic            last_tap;

   assign last_tap = (tap_idx == IDXW'(NTAPS - 1));

`ifdef MAU_SAT_EN
   localparam logic signed [WW+1:0] SUM_MAX = signed'({3'b000, {(WW-1){1'b1}}});
   localparam logic signed [WW+1:0] SUM_MIN = signed'({3'b111, {(WW-1){1'b0}}});

   logic signed [WW+1:0] ext_w;
   logic signed [WW+1:0] ext_x;
   logic signed [WW+1:0] ext_a;
   logic signed [WW+1:0] ref_sum;
   logic                 clamp_hi;
   logic                 clamp_lo;

   // Wide reference sum of the same operands the adder sees, used to detect overflow
   always_comb begin
      ext_w    = signed'({{2{mau_w[WW-1]}}, mau_w});
      ext_x    = signed'({{2{mau_x[WW-1]}}, mau_x});
      ext_a    = signed'({{2{mau_A[WW-1]}}, mau_A});
      ref_sum  = ext_w + (mau_y ? -ext_x : ext_x) + (mau_z ? -ext_a : ext_a);
      clamp_hi = (ref_sum > SUM_MAX);
      clamp_lo = (ref_sum < SUM_MIN);
      if (clamp_hi)
         wr_data = {1'b0, {(WW-1){1'b1}}};
      else if (clamp_lo)
         wr_data = {1'b1, {(WW-1){1'b0}}};
      else
         wr_data = mau_W;
   end
`else
   // Plain wrap-around write-back of the adder result
   always_comb begin
      wr_data = mau_W;
   end
`endif

   // Write strobes for the weight file: write-back in ADD, bulk clear in IDLE
   always_comb begin
      wr_en  = (state == ADD);
      clr_en = (state == IDLE) && clear && !start;
   end

   // Weight register file, cleared by reset or an idle clear request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NTAPS; i++) weights[i] <= '0;
      end else if (wr_en) begin
         weights[tap_idx] <= wr_data;
      end else if (clr_en) begin
         for (int unsigned i = 0; i < NTAPS; i++) weights[i] <= '0;
      end
   end

   // Combinational readout port
   always_comb begin
      rd_data = weights[rd_addr];
   end

   // Pass sequencer with registered handshake, status and adder operand outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tap_idx  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         term_req <= 1'b0;
         mau_w    <= '0;
         mau_x    <= '0;
         mau_A    <= '0;
         mau_y    <= 1'b0;
         mau_z    <= 1'b0;
         mau_a    <= 1'b0;
         mau_b    <= 1'b0;
`ifdef MAU_SAT_EN
         sat_flag <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= REQ;
                  tap_idx  <= '0;
                  busy     <= 1'b1;
                  term_req <= 1'b1;
`ifdef MAU_SAT_EN
                  sat_flag <= 1'b0;
`endif
               end
            end
            REQ: begin
               if (term_valid) begin
                  // Weight is stable while waiting, so it is captured together with the terms
                  mau_w    <= weights[tap_idx];
                  mau_x    <= term_x;
                  mau_A    <= term_a;
                  mau_y    <= term_x_neg;
                  mau_z    <= term_a_neg;
                  mau_a    <= term_x_neg;
                  mau_b    <= term_a_neg;
                  term_req <= 1'b0;
                  state    <= ADD;
               end
            end
            ADD: begin
`ifdef MAU_SAT_EN
               if (clamp_hi || clamp_lo) sat_flag <= 1'b1;
`endif
               if (last_tap) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  tap_idx  <= tap_idx + IDXW'(1);
                  term_req <= 1'b1;
                  state    <= REQ;
               end
            end
            DONE: begin
               tap_idx <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lms_weight_update_ctrl.md
Name: lms_weight_update_ctrl

Overview:
- Sequences the shared 10-bit modified adder unit (3-operand add with per-operand sign inversion and two carry-ins) across all taps of the adaptive filter.
- For each tap it:
  - fetches two correction terms through a valid/ready-style handshake;
  - drives the adder operands, sign controls and carry-ins;
  - writes the result back into an internal weight register file.
- Sits between the error/step-size product stage and the FIR coefficient bank.

Parameters:
- NTAPS, 8, number of filter taps / weights held (2..64)
- IDXW, 3, tap index width, equal to ceil(log2(NTAPS))
- WW, 10, weight and term width; fixed to match the adder unit

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin one update pass over all taps; sampled in IDLE only
- clear  input  1  zero all weights; honoured in IDLE only
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at the end of a pass
- tap_idx  output  IDXW  tap currently being updated
- term_req  output  1  requesting correction terms for tap_idx
- term_valid  input  1  terms present; transfer when term_req && term_valid
- term_x  input  WW  first correction term (magnitude pattern)
- term_x_neg  input  1  subtract term_x instead of adding
- term_a  input  WW  second correction term
- term_a_neg  input  1  subtract term_a instead of adding
- mau_w  output  WW  adder operand w = current weight[tap_idx]
- mau_x  output  WW  adder operand x = latched term_x
- mau_A  output  WW  adder operand A = latched term_a
- mau_y  output  1  adder xor control for x = latched term_x_neg
- mau_z  output  1  adder xor control for A = latched term_a_neg
- mau_a  output  1  adder carry-in a = latched term_x_neg (completes two's complement)
- mau_b  output  1  adder carry-in b = latched term_a_neg
- mau_W  input  WW  adder result, combinational from the mau_* operands
- rd_addr  input  IDXW  weight readout address
- rd_data  output  WW  weight[rd_addr], combinational, valid at all times

Behaviour:
- Reset (asynchronous, any time including mid-pass):
  - all weights to 0; state to IDLE; tap_idx to 0;
  - busy, done, term_req to 0; all mau_* outputs to 0.
- States:
  - IDLE: waits. start=1 → REQ with tap_idx=0 and busy=1 from the next cycle. clear=1 (and start=0) → all weights 0 next cycle, stays in IDLE. start and clear together → start wins, clear ignored.
  - REQ: term_req=1. When term_valid=1 in the same cycle, latch term_x, term_a and both neg flags into operand registers → ADD. Otherwise hold; no timeout.
  - ADD: term_req=0. mau_* outputs driven from the operand registers and weight[tap_idx]. At the end of the cycle, weight[tap_idx] ← mau_W. If tap_idx==NTAPS-1 → DONE; else tap_idx+1 and → REQ.
  - DONE: done=1 and busy=0 for exactly one cycle. tap_idx returns to 0 → IDLE.
- start and clear are ignored while not in IDLE.
- Latency, with term_valid held high: start sampled at edge k; first REQ in cycle k+1; last ADD in cycle k+2·NTAPS; done in cycle k+2·NTAPS+1.
- Arithmetic:
  - weight_new = w + (±x) + (±A), computed mod 2^WW with two's-complement wrap.
  - The controller never modifies mau_W in the default build.
- mau_* outputs hold their last values outside ADD; mau_W is consumed only in ADD.
- rd_data reflects a write-back from the cycle after it occurs.

Optional Feature:
- MAU_SAT_EN defined:
  - the controller forms a WW+2-bit reference sum of sign-extended w, ±x and ±A;
  - if the sum exceeds 2^(WW-1)-1 it writes 511; if below -2^(WW-1) it writes -512; otherwise it writes mau_W;
  - a sticky output sat_flag (1 bit, reset 0, cleared on accepted start) is set on any clamp.
- MAU_SAT_EN undefined: plain wrap-around write-back; no sat_flag port.

Test Plan:
- Reset, then read all addresses → rd_data=0 for every tap; busy=0, done=0, term_req=0.
- Start with term_valid held high, tap0 terms x=5 (+) and A=3 (−), all other taps x=1 (+), A=0 (+) → weight0=2, weights1..7=1; done exactly at cycle k+17 for NTAPS=8.
- Second identical pass, with term_valid stalled 3 cycles per tap → term_req held during each stall, no extra writes; weight0=4, others=2; done at k+17+24.
- Preload weight3=510 via prior passes; apply x=5 (+), A=0 (+) → wrapped result −509 (0x203); with MAU_SAT_EN, result is 511 and sat_flag=1.
- Assert rst in the ADD cycle of tap 4 → all weights 0 immediately, IDLE, busy=0; a new start then runs a full clean pass.
- Pulse clear while busy → no effect; pulse start and clear together in IDLE → pass runs, weights not zeroed first.
